// File: rtl/rs_pkg.sv
// Shared types for the reservation-station issue path:
// opcodes, FU classes and the issue FSM state.
package rs_pkg;

  localparam int RS_SIZE_DEF = 5;

  localparam logic [2:0] OP_ALU = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_FP  = 3'b100;

  typedef enum logic [1:0] {
    FC_ALU  = 2'd0,
    FC_MEM  = 2'd1,
    FC_FP   = 2'd2,
    FC_NONE = 2'd3
  } fu_class_e;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } iss_state_e;

  function automatic fu_class_e op_to_class(
    input logic [2:0] op
  );
    fu_class_e c;
    c = FC_NONE;
    unique case (1'b1)
      (op == OP_ALU): c = FC_ALU;
      (op == OP_LD):  c = FC_MEM;
      (op == OP_ST):  c = FC_MEM;
      (op == OP_FP):  c = FC_FP;
      default:        c = FC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rs_issue_sched_if.sv
// RS-to-execute issue bundle: entry status in,
// per-class valid/ready issue and entry clear out.
interface rs_issue_sched_if
  import rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = $clog2(RS_SIZE),
  parameter int N_FU    = 3
);

  logic [RS_SIZE-1:0]           entry_busy;
  logic [RS_SIZE-1:0][2:0]      entry_opcode;
  logic [RS_SIZE-1:0]           entry_rdy;
  logic [N_FU-1:0]              fu_ready;
  logic [N_FU-1:0]              issue_valid;
  logic [N_FU-1:0][IDX_W-1:0]   issue_idx;
  logic [RS_SIZE-1:0]           entry_clear;

  modport master (
    input  entry_busy,
    input  entry_opcode,
    input  entry_rdy,
    input  fu_ready,
    output issue_valid,
    output issue_idx,
    output entry_clear
  );

  modport slave (
    output entry_busy,
    output entry_opcode,
    output entry_rdy,
    output fu_ready,
    input  issue_valid,
    input  issue_idx,
    input  entry_clear
  );

endinterface

// File: rtl/rs_rr_picker.sv
// Rotating-priority picker: first request at or after
// start (wrapping) wins; one-hot grant plus its index.
module rs_rr_picker #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  always_comb begin
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// Per-class RS issue scheduler (ALU/MEM/FP).
// Define RS_AGE_PRIO_EN for oldest-first selection.
module rs_issue_sched
  import rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = $clog2(RS_SIZE),
  parameter int N_FU    = 3
) (
  input logic              clock,
  input logic              reset,
  input logic              flush,
  rs_issue_sched_if.master bus
);

  typedef logic [RS_SIZE-1:0] vec_t;

  function automatic vec_t onehot(
    input logic [IDX_W-1:0] i
  );
    return vec_t'(1) << i;
  endfunction

  iss_state_e       state_q [N_FU];
  iss_state_e       state_d [N_FU];
  logic [IDX_W-1:0] idx_q   [N_FU];
  logic [IDX_W-1:0] idx_d   [N_FU];

  logic [N_FU-1:0]  pend;
  logic [N_FU-1:0]  alive;
  logic [N_FU-1:0]  hs;
  vec_t             held;
  vec_t             clr;
  vec_t             cand     [N_FU];
  vec_t             gnt      [N_FU];
  logic [IDX_W-1:0] pick_idx [N_FU];
  logic [N_FU-1:0]  pick_any;

  // reset and flush both veto the handshake, so no clear escapes
  always_comb begin
    held = '0;
    clr  = '0;
    for (int k = 0; k < N_FU; k++) begin
      pend[k]  = (state_q[k] == ST_PEND);
      alive[k] = pend[k] & bus.entry_busy[idx_q[k]];
      hs[k]    = alive[k] & bus.fu_ready[k]
                 & ~flush & ~reset;
      if (pend[k]) held = held | onehot(idx_q[k]);
      if (hs[k])   clr  = clr  | onehot(idx_q[k]);
    end
  end

  assign bus.entry_clear = clr;
  assign bus.issue_valid = pend;

  always_comb begin
    bus.issue_idx = '0;
    for (int k = 0; k < N_FU; k++)
      bus.issue_idx[k] = idx_q[k];
  end

  always_comb begin
    for (int k = 0; k < N_FU; k++) begin
      cand[k] = '0;
      for (int i = 0; i < RS_SIZE; i++)
        cand[k][i] = bus.entry_busy[i]
          & bus.entry_rdy[i] & ~held[i]
          & (op_to_class(bus.entry_opcode[i])
             == fu_class_e'(k[1:0]));
    end
  end

  always_comb begin
    for (int k = 0; k < N_FU; k++)
      pick_any[k] = |gnt[k];
  end

`ifdef RS_AGE_PRIO_EN
  logic [2:0] age_q [RS_SIZE];
  vec_t       busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < RS_SIZE; i++)
        age_q[i] <= '0;
    end else begin
      busy_q <= bus.entry_busy;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (bus.entry_busy[i] && !busy_q[i])
          age_q[i] <= '0;
        else if (bus.entry_busy[i] && age_q[i] != 3'd7)
          age_q[i] <= age_q[i] + 3'd1;
      end
    end
  end

  // strict > keeps the lowest index on equal age
  always_comb begin
    logic [2:0] best;
    logic       found;
    best  = '0;
    found = 1'b0;
    for (int k = 0; k < N_FU; k++) begin
      gnt[k]      = '0;
      pick_idx[k] = '0;
      best        = '0;
      found       = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cand[k][i] && (!found || age_q[i] > best)) begin
          found       = 1'b1;
          best        = age_q[i];
          pick_idx[k] = IDX_W'(i);
          gnt[k]      = vec_t'(1) << i;
        end
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q [N_FU];
  logic [IDX_W-1:0] ptr_d [N_FU];
  logic [IDX_W-1:0] start [N_FU];

  // a handshaking class searches from just past the accepted entry
  always_comb begin
    for (int k = 0; k < N_FU; k++) begin
      ptr_d[k] = ptr_q[k];
      if (hs[k])
        ptr_d[k] = (idx_q[k] == IDX_W'(RS_SIZE - 1))
                   ? '0 : idx_q[k] + 1'b1;
      start[k] = ptr_d[k];
    end
  end

  for (genvar k = 0; k < N_FU; k++) begin : g_pick
    rs_rr_picker #(
      .N (RS_SIZE),
      .W (IDX_W)
    ) u_pick (
      .req   (cand[k]),
      .start (start[k]),
      .gnt   (gnt[k]),
      .idx   (pick_idx[k])
    );
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < N_FU; k++) begin
      if (reset) ptr_q[k] <= '0;
      else       ptr_q[k] <= ptr_d[k];
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < N_FU; k++) begin
      state_d[k] = state_q[k];
      idx_d[k]   = idx_q[k];
      if (flush) begin
        state_d[k] = ST_IDLE;
      end else if (pend[k] && !alive[k]) begin
        state_d[k] = ST_IDLE;
      end else if (!pend[k] || hs[k]) begin
        if (pick_any[k]) begin
          state_d[k] = ST_PEND;
          idx_d[k]   = pick_idx[k];
        end else begin
          state_d[k] = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < N_FU; k++) begin
      if (reset) begin
        state_q[k] <= ST_IDLE;
        idx_q[k]   <= '0;
      end else begin
        state_q[k] <= state_d[k];
        idx_q[k]   <= idx_d[k];
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: per-cycle vector table
// plus a scoreboarded ALU selection-order sequence.
module tb_rs_issue_sched;
  import rs_pkg::*;

  localparam int RS = 5;
  localparam int IW = 3;
  localparam int NF = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  rs_issue_sched_if #(
    .RS_SIZE (RS), .IDX_W (IW), .N_FU (NF)
  ) bus ();

  rs_issue_sched #(
    .RS_SIZE (RS), .IDX_W (IW), .N_FU (NF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         fl;
    logic [4:0] busy;
    logic [4:0] rdy;
    logic [14:0] opc;
    logic [2:0] fu;
    logic [2:0] ev;
    logic [8:0] eidx;
    logic [4:0] eclr;
    bit         ci;
  } vec_t;

  vec_t tbl[$];
  int   exp_q[$];

  function automatic logic [14:0] op_at(int i, logic [2:0] op);
    return 15'(op) << (3 * i);
  endfunction

  function automatic logic [8:0] ix(int k, int v);
    return 9'(v) << (3 * k);
  endfunction

  function automatic vec_t mk(
    bit rst, bit fl, logic [4:0] busy, logic [4:0] rdy,
    logic [14:0] opc, logic [2:0] fu, logic [2:0] ev,
    logic [8:0] eidx, logic [4:0] eclr, bit ci
  );
    vec_t v;
    v.rst = rst; v.fl = fl; v.busy = busy; v.rdy = rdy;
    v.opc = opc; v.fu = fu; v.ev = ev; v.eidx = eidx;
    v.eclr = eclr; v.ci = ci;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, req);
    end
  endtask

  task automatic apply_row(int r, vec_t v);
    logic [8:0] mask;
    reset = v.rst;
    flush = v.fl;
    bus.entry_busy   = v.busy;
    bus.entry_rdy    = v.rdy;
    bus.entry_opcode = v.opc;
    bus.fu_ready     = v.fu;
    #1;
    chk($sformatf("row%0d valid", r),
        32'(bus.issue_valid), 32'(v.ev));
    mask = v.ci ? 9'h1ff
                : {{3{v.ev[2]}}, {3{v.ev[1]}}, {3{v.ev[0]}}};
    if (mask != 9'h0)
      chk($sformatf("row%0d idx", r),
          32'(bus.issue_idx & mask), 32'(v.eidx & mask));
    chk($sformatf("row%0d clear", r),
        32'(bus.entry_clear), 32'(v.eclr));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [14:0] o_ld, o_fp, o_par, o_alu0, o_bad;
    logic [14:0] o_rr;
    logic [4:0]  clr;
    int          e;

    bus.entry_busy   = '0;
    bus.entry_rdy    = '0;
    bus.entry_opcode = '0;
    bus.fu_ready     = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    o_ld   = op_at(1, OP_LD);
    o_fp   = op_at(3, OP_FP);
    o_par  = op_at(0, OP_ALU) | op_at(2, OP_ST)
           | op_at(3, OP_FP);
    o_alu0 = op_at(0, OP_ALU);
    o_bad  = op_at(0, 3'b111);

    // reset held, then released idle
    tbl.push_back(mk(1,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,1));
    tbl.push_back(mk(1,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,1));
    tbl.push_back(mk(0,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,1));
    tbl.push_back(mk(0,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,1));
    // single LD issue on entry 1
    tbl.push_back(mk(0,0,5'h02,5'h02,o_ld,3'b010,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h02,5'h02,o_ld,3'b010,3'b010,
                     ix(1,1),5'h02,0));
    tbl.push_back(mk(0,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,0));
    // FP entry 3 stalled three cycles then accepted
    tbl.push_back(mk(0,0,5'h08,5'h08,o_fp,3'b000,3'b000,0,5'h00,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,5'h08,5'h08,o_fp,3'b000,3'b100,
                       ix(2,3),5'h00,0));
    tbl.push_back(mk(0,0,5'h08,5'h08,o_fp,3'b100,3'b100,
                     ix(2,3),5'h08,0));
    tbl.push_back(mk(0,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,0));
    // three classes hand off together
    tbl.push_back(mk(0,0,5'h0d,5'h0d,o_par,3'b111,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h0d,5'h0d,o_par,3'b111,3'b111,
                     ix(0,0)|ix(1,2)|ix(2,3),5'h0d,0));
    tbl.push_back(mk(0,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,0));
    // flush while pending, then withdraw by dropping busy
    tbl.push_back(mk(0,0,5'h01,5'h01,o_alu0,3'b000,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,1,5'h01,5'h01,o_alu0,3'b001,3'b001,
                     ix(0,0),5'h00,0));
    tbl.push_back(mk(0,0,5'h01,5'h01,o_alu0,3'b000,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h00,5'h01,o_alu0,3'b001,3'b001,
                     ix(0,0),5'h00,0));
    tbl.push_back(mk(0,0,5'h00,5'h01,o_alu0,3'b001,3'b000,0,5'h00,0));
    // reset mid-pending: no clear, everything back to zero
    tbl.push_back(mk(0,0,5'h01,5'h01,o_alu0,3'b000,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h01,5'h01,o_alu0,3'b000,3'b001,
                     ix(0,0),5'h00,0));
    tbl.push_back(mk(1,0,5'h01,5'h01,o_alu0,3'b001,3'b001,
                     ix(0,0),5'h00,0));
    tbl.push_back(mk(0,0,5'h00,5'h00,0,3'b000,3'b000,0,5'h00,1));
    // unknown opcode and operands-not-ready never issue
    tbl.push_back(mk(0,0,5'h01,5'h01,o_bad,3'b111,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h01,5'h01,o_bad,3'b111,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h01,5'h00,o_alu0,3'b001,3'b000,0,5'h00,0));
    tbl.push_back(mk(0,0,5'h01,5'h00,o_alu0,3'b001,3'b000,0,5'h00,0));

    foreach (tbl[r]) apply_row(r, tbl[r]);

    // ALU selection order, scoreboarded
    reset = 1'b1;
    flush = 1'b0;
    bus.entry_busy = '0;
    bus.entry_rdy  = '0;
    bus.fu_ready   = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    o_rr = op_at(0, OP_ALU) | op_at(2, OP_ALU)
         | op_at(4, OP_ALU);
    bus.entry_opcode = o_rr;
`ifdef RS_AGE_PRIO_EN
    exp_q = '{4, 2, 0};
`else
    exp_q = '{0, 2, 4, 0, 2};
    bus.entry_busy = 5'b10101;
    bus.entry_rdy  = 5'b10101;
    bus.fu_ready   = 3'b001;
`endif
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
`ifdef RS_AGE_PRIO_EN
      if (c == 0) bus.entry_busy[4] = 1'b1;
      if (c == 1) bus.entry_busy[2] = 1'b1;
      if (c == 2) bus.entry_busy[0] = 1'b1;
      bus.entry_rdy = 5'b10101;
      bus.fu_ready  = (c >= 3) ? 3'b001 : 3'b000;
`endif
      #1;
      if (bus.issue_valid[0] && bus.fu_ready[0]) begin
        e = exp_q.pop_front();
        chk("order idx", 32'(bus.issue_idx[0]), 32'(e));
        chk("order clear", 32'(bus.entry_clear),
            32'(5'(1) << e));
      end
      clr = bus.entry_clear;
      @(posedge clock);
      #1;
`ifdef RS_AGE_PRIO_EN
      bus.entry_busy = bus.entry_busy & ~clr;
`else
      clr = '0;
`endif
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL order timeout: %0d issues missing, expected 0",
               exp_q.size());
    end

    bus.entry_busy = '0;
    bus.fu_ready   = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("drain valid", 32'(bus.issue_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for the reservation station.
- Each cycle it looks at which RS entries are busy and have both operands available, i.e. tags T1 and T2 are 0.
- For each functional-unit class (ALU, MEM, FP) it selects one entry and presents it with a valid/ready handshake.
- When the functional unit accepts, it pulses a one-hot clear back to the RS so the entry is freed.
- It sits between `rs` and the execute stage.

## Interface
Parameters:
- `RS_SIZE`, 5, number of RS entries.
- `IDX_W`, `$clog2(RS_SIZE)`, entry index width.
- `N_FU`, 3, number of FU classes (0=ALU, 1=MEM, 2=FP).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous; drops all pending issues (mispredict/squash).
- `entry_busy` in `[RS_SIZE]`: RS entry occupied.
- `entry_opcode` in `[RS_SIZE][2:0]`: 3'b001 ALU, 3'b010 LD, 3'b011 ST, 3'b100 FP; any other value is never issued.
- `entry_rdy` in `[RS_SIZE]`: operands available (T1==0 && T2==0).
- `fu_ready` in `[N_FU]`: FU can accept an issue this cycle.
- `issue_valid` out `[N_FU]`: issue offered to the FU.
- `issue_idx` out `[N_FU][IDX_W]`: RS entry being issued.
- `entry_clear` out `[RS_SIZE]`: one-hot per accepted issue; pulse frees the entry in RS.

## Operation
- Class mapping: ALU→0; LD and ST→1; FP→2.
- Candidate for class k: `entry_busy & entry_rdy`, class matches k, and entry not held by any pending issue.
- Per class, two states:
  - IDLE: if any candidate exists, select one, register `issue_idx`, set `issue_valid`, go to PEND.
  - PEND: hold `issue_valid`=1 and `issue_idx` stable until `fu_ready[k]`. On handshake, assert `entry_clear[idx]` the same cycle, then go to IDLE.
- Selection (default): round-robin.
  - Per-class pointer `ptr[k]`.
  - Search starts at `ptr[k]` and wraps modulo `RS_SIZE`.
  - On handshake, `ptr[k]` ← idx+1, wrapping to 0 when idx == `RS_SIZE`-1.
- Entry dropped while pending (`entry_busy[idx]`=0 in PEND): the issue is withdrawn. Next cycle `issue_valid`=0, no clear is generated, state returns to IDLE.
- `flush`: every class goes to IDLE with `issue_valid`=0 next cycle. Pointers are kept. No `entry_clear`, even if `fu_ready` is high in the flush cycle.
- Multiple classes may hand off in the same cycle; `entry_clear` is then multi-hot, with one bit per handshaking class.
- No entry is ever offered to two classes, or offered twice.

## Timing
- Reset values: `issue_valid`=0, `issue_idx`=0, `entry_clear`=0, all `ptr`=0, state IDLE.
- `reset` dominates `flush`. Reset applied mid-PEND drops the issue with no clear.
- Latency: a candidate sampled at edge N gives `issue_valid` high after edge N.
- Handshake:
  - It completes in the cycle where `issue_valid[k]` && `fu_ready[k]`.
  - `entry_clear` is combinational from that condition, so it is valid in that same cycle.
  - The next selection for class k occurs at that same edge. It excludes the accepted entry, so back-to-back issues per class are possible: one per cycle.
- `fu_ready` asserted while `issue_valid`=0 has no effect.

## Configuration
- `RS_AGE_PRIO_EN` defined:
  - Each entry has a 3-bit saturating age counter.
  - The counter loads 0 in the cycle `entry_busy` rises.
  - Otherwise it increments each cycle while busy, saturating at 7.
  - Selection picks the candidate with the highest age; ties go to the lowest index.
  - Pointers are not used.
- `RS_AGE_PRIO_EN` undefined: round-robin selection as above; no age state exists.

## Structure
- Package `rs_pkg` holds:
  - The opcode constants ALU/LD/ST/FP.
  - The FU class enum `fu_class_e`.
  - The function `op_to_class()`.
  - `RS_SIZE_DEF`.
- Sub-module `rs_rr_picker`: parameterized rotating-priority picker (request vector plus start pointer → one-hot grant and index). Instantiated once per class; bypassed when `RS_AGE_PRIO_EN` is defined.

## Test plan
- Reset: hold reset 2 cycles → all outputs 0. Release with no requests → outputs stay 0.
- Single issue:
  - Stimulus: entry 1 busy/rdy, opcode LD, `fu_ready[1]`=1.
  - Expect: `issue_valid[1]`=1 and `issue_idx[1]`=1 after the next edge.
  - Expect: `entry_clear`=5'b00010 in that cycle.
- Stall then accept:
  - Stimulus: FP entry 3 ready, `fu_ready[2]`=0 for 3 cycles, then 1.
  - Expect: `issue_idx[2]`=3 held stable for 4 cycles, then a single clear pulse 5'b01000.
- Round-robin wrap:
  - Stimulus: ALU entries 0, 2, 4 continuously ready, `fu_ready[0]`=1.
  - Expect issue order 0, 2, 4, 0.
  - With `RS_AGE_PRIO_EN` defined: the oldest entry issues first.
- Parallel classes:
  - Stimulus: ALU entry 0, ST entry 2, FP entry 3 all ready, all `fu_ready`=1.
  - Expect: three issues in the same cycle and `entry_clear`=5'b01101.
- Flush and withdraw:
  - Flush while PEND → `issue_valid`=0 next cycle and no clear.
  - Drop `entry_busy[idx]` while PEND → the issue is withdrawn and no clear is generated.
